ffmul_32bit_seq: RTL

Sequential IEEE-754 single-precision multiplier: the inverse-operation companion to the 32-bit floating-point divider. It shares the divider's operand, start/ready and cycle-count interface, so both can sit behind the same FPU operand path and bench. It uses a radix-2 shift-and-add datapath with one multiplier bit per cycle, followed by normalization and round-to-nearest-even.

---
 rtl/ffmul_32bit_seq.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/ffmul_32bit_seq.sv
// Sequential IEEE-754 single-precision multiplier.
// Radix-2 shift-and-add significand product (one multiplier bit per cycle),
// then normalization and round-to-nearest-even. Denormals read as signed zero.
module ffmul_32bit_seq #(
  parameter int OPERAND_WIDTH     = 32,
  parameter int EXP_WIDTH         = 8,
  parameter int SIGNIFICAND_WIDTH = 24,
  parameter int PRECISION_WIDTH   = SIGNIFICAND_WIDTH + 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [OPERAND_WIDTH-1:0]         op_1,
  input  logic [OPERAND_WIDTH-1:0]         op_2,
  input  logic                             mul_start,
  output logic                             sign,
  output logic [EXP_WIDTH-1:0]             biased_exp,
  output logic [SIGNIFICAND_WIDTH-2:0]     fraction,
  output logic                             mul_ready,
  output logic [$clog2(OPERAND_WIDTH)-1:0] count
);

  localparam int SW = SIGNIFICAND_WIDTH;
  localparam int FW = SIGNIFICAND_WIDTH - 1;
  localparam int PW = 2 * SIGNIFICAND_WIDTH;
  localparam int XW = EXP_WIDTH + 2;
  localparam int CW = $clog2(OPERAND_WIDTH);
  localparam int BW = $clog2(SIGNIFICAND_WIDTH);

  localparam logic signed [XW-1:0] BIAS_S    = XW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX_S = XW'((1 << EXP_WIDTH) - 1);
  localparam logic signed [XW-1:0] ONE_S     = XW'(1);
  localparam logic signed [XW-1:0] ZERO_S    = '0;
  localparam logic [BW-1:0]        LAST_BIT  = BW'(SIGNIFICAND_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, UNPACK, CALC, NORM, ROUND, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     sign_q, sign_d;
  logic [EXP_WIDTH-1:0]     exp_out_q, exp_out_d;
  logic [FW-1:0]            frac_q, frac_d;
  logic                     ready_q, ready_d;
  logic [CW-1:0]            count_q, count_d;

  logic [OPERAND_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [SW-1:0]            mcand_q, mcand_d, mplier_q, mplier_d;
  logic [PW-1:0]            acc_q, acc_d;
  logic signed [XW-1:0]     exp_q, exp_d;
  logic [PRECISION_WIDTH-1:0] prec_q, prec_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic                     psign_q, psign_d;

  // Operand field views of the captured operands
  logic                 s1, s2;
  logic [EXP_WIDTH-1:0] e1, e2;
  logic [FW-1:0]        f1, f2;
  logic                 zero1, zero2, inf1, inf2, nan1, nan2;
  logic [SW:0]          acc_sum;

  assign s1    = op1_q[OPERAND_WIDTH-1];
  assign s2    = op2_q[OPERAND_WIDTH-1];
  assign e1    = op1_q[OPERAND_WIDTH-2 -: EXP_WIDTH];
  assign e2    = op2_q[OPERAND_WIDTH-2 -: EXP_WIDTH];
  assign f1    = op1_q[FW-1:0];
  assign f2    = op2_q[FW-1:0];
  assign zero1 = (e1 == '0);
  assign zero2 = (e2 == '0);
  assign inf1  = (e1 == '1) && (f1 == '0);
  assign inf2  = (e2 == '1) && (f2 == '0);
  assign nan1  = (e1 == '1) && (f1 != '0);
  assign nan2  = (e2 == '1) && (f2 != '0);
  assign acc_sum = {1'b0, acc_q[PW-1:SW]} + {1'b0, mcand_q};

  // Round {mant,g,r,s} to nearest-even, renormalize a carry-out, saturate to
  // inf on overflow and flush to zero on underflow. Returns {exp, fraction}.
  function automatic logic [EXP_WIDTH+FW-1:0] round_pack(
    input logic [PRECISION_WIDTH-1:0] p,
    input logic signed [XW-1:0]       e
  );
    logic [SW-1:0]        mant;
    logic [SW:0]          sum;
    logic                 inc;
    logic signed [XW-1:0] ex;
    mant = p[PRECISION_WIDTH-1:3];
    inc  = p[2] & (p[1] | p[0] | mant[0]);
    sum  = {1'b0, mant} + {{SW{1'b0}}, inc};
    ex   = e;
    if (sum[SW]) begin
      mant = sum[SW:1];
      ex   = ex + ONE_S;
    end else begin
      mant = sum[SW-1:0];
    end
    if (ex >= EXP_MAX_S)   return {{EXP_WIDTH{1'b1}}, {FW{1'b0}}};
    else if (ex <= ZERO_S) return '0;
    else                   return {ex[EXP_WIDTH-1:0], mant[FW-1:0]};
  endfunction

  // Next-state, datapath and output computation
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_out_d = exp_out_q;
    frac_d    = frac_q;
    ready_d   = ready_q;
    count_d   = count_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    exp_d     = exp_q;
    prec_d    = prec_q;
    bit_cnt_d = bit_cnt_q;
    psign_d   = psign_q;
    unique case (state_q)
      IDLE: begin
        if (mul_start) begin
          op1_d   = op_1;
          op2_d   = op_2;
          count_d = '0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        count_d   = count_q + 1'b1;
        psign_d   = s1 ^ s2;
        exp_d     = $signed({2'b00, e1}) + $signed({2'b00, e2}) - BIAS_S;
        mcand_d   = {1'b1, f1};
        mplier_d  = {1'b1, f2};
        acc_d     = '0;
        bit_cnt_d = '0;
        if (nan1 || nan2 || (inf1 && zero2) || (inf2 && zero1)) begin
          sign_d    = 1'b0;
          exp_out_d = '1;
          frac_d    = {1'b1, {(FW-1){1'b0}}};
          state_d   = DONE;
        end else if (inf1 || inf2) begin
          sign_d    = s1 ^ s2;
          exp_out_d = '1;
          frac_d    = '0;
          state_d   = DONE;
        end else if (zero1 || zero2) begin
          sign_d    = s1 ^ s2;
          exp_out_d = '0;
          frac_d    = '0;
          state_d   = DONE;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        count_d   = count_q + 1'b1;
        acc_d     = mplier_q[0] ? {acc_sum, acc_q[SW-1:1]} : {1'b0, acc_q[PW-1:1]};
        mplier_d  = mplier_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) state_d = NORM;
      end
      NORM: begin
        count_d = count_q + 1'b1;
        if (acc_q[PW-1]) begin
          prec_d = {acc_q[PW-1:SW], acc_q[SW-1], acc_q[SW-2], |acc_q[SW-3:0]};
          exp_d  = exp_q + ONE_S;
        end else begin
          prec_d = {acc_q[PW-2:SW-1], acc_q[SW-2], acc_q[SW-3], |acc_q[SW-4:0]};
        end
        state_d = ROUND;
      end
      ROUND: begin
        count_d              = count_q + 1'b1;
        sign_d               = psign_q;
        {exp_out_d, frac_d}  = round_pack(prec_q, exp_q);
        ready_d              = 1'b1;
        state_d              = DONE;
      end
      DONE: begin
        if (!ready_q) begin
          ready_d = 1'b1;
        end else if (!mul_start) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      exp_out_q <= '0;
      frac_q    <= '0;
      ready_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      exp_out_q <= exp_out_d;
      frac_q    <= frac_d;
      ready_q   <= ready_d;
      count_q   <= count_d;
    end
  end

  // Datapath registers; always reloaded before use, so no reset
  always_ff @(posedge clk) begin
    op1_q     <= op1_d;
    op2_q     <= op2_d;
    mcand_q   <= mcand_d;
    mplier_q  <= mplier_d;
    acc_q     <= acc_d;
    exp_q     <= exp_d;
    prec_q    <= prec_d;
    bit_cnt_q <= bit_cnt_d;
    psign_q   <= psign_d;
  end

  assign sign       = sign_q;
  assign biased_exp = exp_out_q;
  assign fraction   = frac_q;
  assign mul_ready  = ready_q;
  assign count      = count_q;

endmodule
